// File: rtl/config_chain_loader.sv
// Configuration chain loader: serialises bitstream words LSB-first onto a
// tile shift chain and strobes the chain's set line after CHAIN_LEN bits.
module config_chain_loader #(
    parameter int WORD_W = 32,
    parameter int CHAIN_LEN = 72,
    localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              shift_out,
    output logic              cen,
    output logic              set_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bits_loaded
);

    localparam int WL_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_SET,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [WL_W-1:0]   left_q;
    logic [CNT_W-1:0]  bits_q;

    logic [31:0]     rem_d;
    logic [WL_W-1:0] take_d;
    logic            last_d;
    logic            full_d;

    // Bits to take from the next word: a full word, or whatever the chain still needs.
    always_comb begin
        rem_d  = 32'(CHAIN_LEN) - 32'(bits_q);
        take_d = (rem_d > 32'(WORD_W)) ? WL_W'(WORD_W) : WL_W'(rem_d);
        last_d = (left_q == WL_W'(1));
        full_d = (bits_q == CNT_W'(CHAIN_LEN - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            left_q  <= '0;
            bits_q  <= '0;
        end else if (abort && state_q != S_IDLE) begin
            state_q <= S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_q <= S_LOAD;
                        bits_q  <= '0;
                    end
                end
                S_LOAD: begin
                    if (word_valid) begin
                        shreg_q <= word_data;
                        left_q  <= take_d;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg_q <= shreg_q >> 1;
                    left_q  <= left_q - WL_W'(1);
                    bits_q  <= bits_q + CNT_W'(1);
                    if (last_d) begin
                        state_q <= full_d ? S_SET : S_LOAD;
                    end
                end
                S_SET: begin
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only.
    assign word_ready  = (state_q == S_LOAD);
    assign cen         = (state_q == S_SHIFT);
    assign shift_out   = cen & shreg_q[0];
    assign set_out     = (state_q == S_SET);
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q == S_LOAD) || (state_q == S_SHIFT) ||
                         (state_q == S_SET);
    assign bits_loaded = bits_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: table-driven loads with a bit scoreboard,
// plus reset, abort and single-word chain sequences.
module tb_config_chain_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, word_valid;
    logic [31:0] word_data;
    logic        word_ready, shift_out, cen, set_out, busy, done;
    logic [6:0]  bits_loaded;

    logic        s_start, s_abort, s_valid;
    logic [31:0] s_data;
    logic        s_ready, s_shift, s_cen, s_set, s_busy, s_done;
    logic [5:0]  s_bits;

    int n_cmp = 0;
    int n_err = 0;

    bit q[$];
    bit q32[$];

    typedef struct {
        logic [31:0] w0, w1, w2;
        int stall;
        int abort_at;
        int exp_cen;
        int exp_set;
        int exp_done;
        int exp_bits;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    config_chain_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .shift_out(shift_out), .cen(cen),
        .set_out(set_out), .busy(busy), .done(done),
        .bits_loaded(bits_loaded)
    );

    config_chain_loader #(.WORD_W(32), .CHAIN_LEN(32)) dut32 (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
        .word_data(s_data), .word_valid(s_valid),
        .word_ready(s_ready), .shift_out(s_shift), .cen(s_cen),
        .set_out(s_set), .busy(s_busy), .done(s_done),
        .bits_loaded(s_bits)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [31:0] words[3];
        int widx, stall_left, cenc, setc, setcyc, donec, donecyc;
        int pushed, n, bl;
        bit fin;
        words[0] = v.w0; words[1] = v.w1; words[2] = v.w2;
        widx = 0; stall_left = v.stall; cenc = 0; setc = 0; setcyc = 0;
        donec = 0; donecyc = 0; pushed = 0; bl = -1; fin = 0;
        q.delete();
        @(negedge clk);
        start = 1'b1; abort = 1'b0; word_valid = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 300 && !fin; k++) begin
            @(negedge clk);
            abort = 1'b0;
            if (k == 1) begin
                chk($sformatf("v%0d start_bits", id), 32'(bits_loaded), 0);
                chk($sformatf("v%0d start_busy", id), 32'(busy), 1);
            end
            if (cen) begin
                cenc++;
                if (q.size() == 0) begin
                    chk($sformatf("v%0d extra_cen@%0d", id, k), 1, 0);
                end else begin
                    chk($sformatf("v%0d shift_out@%0d", id, k),
                        32'(shift_out), 32'(q.pop_front()));
                end
            end else begin
                chk($sformatf("v%0d shift_idle@%0d", id, k), 32'(shift_out), 0);
            end
            if (set_out) begin setc++; setcyc = k; end
            if (done) begin donec++; donecyc = k; end
            if (k > 1 && !busy) begin fin = 1; bl = int'(bits_loaded); end
            if (v.abort_at > 0 && cen && cenc == v.abort_at + 1) abort = 1'b1;
            word_data  = (widx < 3) ? words[widx] : 32'h0;
            word_valid = (widx < 3) && !(widx == 1 && stall_left > 0);
            if (word_ready && !word_valid) begin
                chk($sformatf("v%0d stall_cen@%0d", id, k), 32'(cen), 0);
                stall_left--;
            end
            if (word_ready && word_valid && !abort) begin
                n = (72 - pushed < 32) ? 72 - pushed : 32;
                for (int i = 0; i < n; i++) q.push_back(words[widx][i]);
                pushed += n;
                widx++;
            end
        end
        abort = 1'b0;
        word_valid = 1'b0;
        chk($sformatf("v%0d finished", id), 32'(fin), 1);
        chk($sformatf("v%0d cen_count", id), cenc, v.exp_cen);
        chk($sformatf("v%0d set_pulses", id), setc, (v.exp_set != 0) ? 1 : 0);
        chk($sformatf("v%0d set_cycle", id), setcyc, v.exp_set);
        chk($sformatf("v%0d done_cycle", id), donecyc, v.exp_done);
        chk($sformatf("v%0d done_pulses", id), donec, (v.exp_done != 0) ? 1 : 0);
        chk($sformatf("v%0d bits_loaded", id), bl, v.exp_bits);
        @(negedge clk);
        chk($sformatf("v%0d idle_after", id), 32'({busy, cen, set_out, done}), 0);
    endtask

    initial begin
        int setc, cenc, hs, setcyc, donecyc, bl;
        bit fin;
        logic [31:0] w32;

        vecs[0] = '{32'hDEADBEEF, 32'h12345678, 32'h000000A5, 0, 0, 72, 76, 77, 72};
        vecs[1] = '{32'hDEADBEEF, 32'h12345678, 32'h000000A5, 5, 0, 72, 81, 82, 72};
        vecs[2] = '{32'hDEADBEEF, 32'h12345678, 32'h000000A5, 0, 40, 41, 0, 0, 40};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFF3C, 0, 0, 72, 76, 77, 72};
        vecs[4] = '{32'h80000001, 32'h5A5AA5A5, 32'h0F0F0F81, 3, 0, 72, 79, 80, 72};

        rst = 1'b0;
        start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
        s_start = 1'b0; s_abort = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({word_ready, shift_out, cen, set_out, busy, done}), 0);
        chk("reset_bits", 32'(bits_loaded), 0);

        // start and abort together in IDLE must leave the loader idle
        start = 1'b1; abort = 1'b1; word_valid = 1'b1; word_data = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'({busy, word_ready}), 0);
        @(negedge clk);
        chk("start_abort_cen", 32'({cen, busy}), 0);
        word_valid = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Single-word chain; a start pulse while busy is ignored.
        w32 = 32'hCAFEF00D;
        q32.delete();
        setc = 0; cenc = 0; hs = 0; setcyc = 0; donecyc = 0; bl = -1; fin = 0;
        @(negedge clk);
        s_start = 1'b1; s_valid = 1'b0;
        @(posedge clk);
        #1 s_start = 1'b0;
        for (int k = 1; k <= 100 && !fin; k++) begin
            @(negedge clk);
            if (s_cen) begin
                cenc++;
                if (q32.size() == 0) chk($sformatf("c32 extra_cen@%0d", k), 1, 0);
                else chk($sformatf("c32 shift_out@%0d", k), 32'(s_shift),
                         32'(q32.pop_front()));
            end
            if (s_set) begin setc++; setcyc = k; end
            if (s_done) donecyc = k;
            if (k > 1 && !s_busy) begin fin = 1; bl = int'(s_bits); end
            s_start = (k == 10);
            s_valid = 1'b1;
            s_data  = w32;
            if (s_ready) begin
                hs++;
                for (int i = 0; i < 32; i++) q32.push_back(w32[i]);
            end
        end
        s_start = 1'b0; s_valid = 1'b0;
        chk("c32 finished", 32'(fin), 1);
        chk("c32 handshakes", hs, 1);
        chk("c32 cen_count", cenc, 32);
        chk("c32 set_pulses", setc, 1);
        chk("c32 set_cycle", setcyc, 34);
        chk("c32 done_cycle", donecyc, 35);
        chk("c32 bits_loaded", bl, 32);
        repeat (3) @(negedge clk);
        chk("c32 idle_after", 32'({s_busy, s_cen}), 0);

        // Asynchronous reset in the middle of a shift.
        word_data = 32'hDEADBEEF; word_valid = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 chk("pre_reset_cen", 32'(cen), 1);
        #1 rst = 1'b0;
        #1 chk("async_reset_outputs",
               32'({word_ready, shift_out, cen, set_out, busy, done}), 0);
        chk("async_reset_bits", 32'(bits_loaded), 0);
        @(negedge clk);
        rst = 1'b1;
        setc = 0; cenc = 0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (set_out) setc++;
            if (cen || done) cenc++;
        end
        chk("post_reset_no_set", setc, 0);
        chk("post_reset_no_activity", cenc, 0);
        word_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
